// File: rtl/inst_sram_bridge.sv
// inst_sram_bridge: instruction-fetch front end between the CPU fetch stage and
// an sram-like read bus. One read is issued per fetch, the returned word is
// forwarded to decode as instrF, and inst_on stalls fetch while a read is in
// flight.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   pcF, inst_en             fetch PC and fetch-permitted (low = bubble)
//   longstall, flush         pipeline freeze, exception/eret redirect
//   instrF, inst_on          instruction to decode, fetch stall
//   inst_req/wr/size/addr/wdata   sram-like request side
//   inst_addr_ok/data_ok/rdata    sram-like response side
module inst_sram_bridge #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned INST_SIZE = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] pcF,
  input  logic          inst_en,
  input  logic          longstall,
  input  logic          flush,
  output logic [DW-1:0] instrF,
  output logic          inst_on,
  output logic          inst_req,
  output logic          inst_wr,
  output logic [1:0]    inst_size,
  output logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_wdata,
  input  logic          inst_addr_ok,
  input  logic          inst_data_ok,
  input  logic [DW-1:0] inst_rdata
);

  // S_DISCARD doubles as the "flush pending" marker: a read is in flight
  // whose data must be dropped.
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] instr_buf_q, instr_buf_d;
  logic          fetch_go;

  // A fetch is only requested for an aligned PC that is not being redirected.
  assign fetch_go = inst_en & ~flush;

  // Next-state and instruction buffer update
  always_comb begin
    state_d     = state_q;
    instr_buf_d = instr_buf_q;
    case (state_q)
      S_REQ: begin
        if (fetch_go && inst_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (!flush) begin
            instr_buf_d = inst_rdata;
            state_d     = longstall ? S_HOLD : S_REQ;
          end else begin
            state_d = S_REQ;
          end
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (inst_data_ok) state_d = S_REQ;
      end
      S_HOLD: begin
        if (!longstall || flush) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_REQ;
      instr_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  // Fetch-side and request outputs; all forced quiet while in reset
  always_comb begin
    inst_req = 1'b0;
    inst_on  = 1'b0;
    instrF   = '0;
    if (resetn) begin
      case (state_q)
        S_REQ: begin
          inst_req = fetch_go;
          inst_on  = fetch_go;
          instrF   = inst_en ? instr_buf_q : '0;
        end
        S_WAIT: begin
          inst_on = ~inst_data_ok;
          // Bypass so decode can capture the word in the data_ok cycle.
          instrF  = (inst_data_ok && !flush) ? inst_rdata : instr_buf_q;
        end
        S_DISCARD: begin
          inst_on = 1'b1;
          instrF  = instr_buf_q;
        end
        S_HOLD: begin
          instrF = instr_buf_q;
        end
        default: begin
          instrF = instr_buf_q;
        end
      endcase
    end
  end

  assign inst_addr  = pcF;
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'(INST_SIZE);
  assign inst_wdata = '0;

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Randomized bench for inst_sram_bridge: a fetch-stage driver and an sram-like
// slave drive the DUT; a negedge monitor checks bus protocol and compares each
// instruction captured by the decode stage against the expected memory word.
module tb_inst_sram_bridge;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          NCYC = 3000;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] pcF;
  logic          inst_en;
  logic          longstall;
  logic          flush;
  logic [DW-1:0] instrF;
  logic          inst_on;
  logic          inst_req;
  logic          inst_wr;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_wdata;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;

  always #5 clk = ~clk;

  inst_sram_bridge #(.AW(AW), .DW(DW), .INST_SIZE(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcF          (pcF),
    .inst_en      (inst_en),
    .longstall    (longstall),
    .flush        (flush),
    .instrF       (instrF),
    .inst_on      (inst_on),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  int checks   = 0;
  int failures = 0;

  // Expected instruction for the PC currently presented to fetch.
  logic [31:0] exp_q[$];

  // Monitor -> driver handshakes
  bit          hs_flag  = 1'b0;
  logic [31:0] hs_addr  = '0;
  bit          cap_flag = 1'b0;
  int          cap_cnt  = 0;

  // Slave state
  bit          out_pend = 1'b0;
  logic [31:0] out_addr = '0;
  int          dcnt     = 0;

  int          ls_run   = 0;
  bit          rst_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed per-address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h24080001;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return {a[31:2], 2'b00} + 32'd4;
  endfunction

  function automatic logic [31:0] redirect_pc();
    case ($urandom_range(0, 3))
      0:       return 32'hBFC0_0380;
      1:       return 32'hBFC0_0002;
      2:       return 32'hBFC0_0000 + 32'($urandom_range(0, 255) << 2);
      default: return 32'h8000_0000 + 32'($urandom_range(0, 1023) << 2);
    endcase
  endfunction

  // Present a new fetch PC and record what decode must eventually receive.
  task automatic set_pc(input logic [31:0] a);
    pcF     = a;
    inst_en = (a[1:0] == 2'b00);
    exp_q.delete();
    exp_q.push_back(inst_en ? mem_word(a) : 32'h0);
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input int cyc);
    bit zw;
    zw = (cyc < 20);
    if (!resetn) begin
      resetn   = 1'b1;
      cap_flag = 1'b0;
      hs_flag  = 1'b0;
      set_pc(32'hBFC0_0000);
    end else if (!rst_done && cyc >= 400 && out_pend) begin
      resetn       = 1'b0;
      rst_done     = 1'b1;
      out_pend     = 1'b0;
      hs_flag      = 1'b0;
      cap_flag     = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'hDEAD_BEEF;
      flush        = 1'b0;
      longstall    = 1'b0;
      inst_addr_ok = 1'($urandom_range(0, 1));
      return;
    end else begin
      if (flush)         set_pc(redirect_pc());
      else if (cap_flag) set_pc(next_pc(pcF));
      cap_flag = 1'b0;
    end

    // Slave: accept, then return data 1..4 cycles later.
    if (hs_flag) begin
      out_pend = 1'b1;
      out_addr = hs_addr;
      dcnt     = zw ? 1 : int'($urandom_range(1, 4));
      hs_flag  = 1'b0;
    end
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
    if (out_pend) begin
      if (dcnt <= 1) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_word(out_addr);
        out_pend     = 1'b0;
      end else begin
        dcnt--;
      end
    end
    inst_addr_ok = zw ? 1'b1 : ($urandom_range(0, 2) != 0);

    // Pipeline: bursts of longstall, occasional flush.
    if (zw) begin
      longstall = 1'b0;
      flush     = 1'b0;
    end else begin
      if (ls_run > 0) ls_run--;
      else if ($urandom_range(0, 7) == 0) ls_run = int'($urandom_range(1, 6));
      longstall = (ls_run > 0);
      flush     = ($urandom_range(0, 11) == 0);
    end
  endtask

  // Driver
  initial begin
    resetn       = 1'b0;
    pcF          = 32'hBFC0_0000;
    inst_en      = 1'b1;
    longstall    = 1'b0;
    flush        = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    resetn       = 1'b1;
    inst_addr_ok = 1'b1;
    set_pc(32'hBFC0_0000);
    for (int cyc = 1; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      // Zero-wait slave: one instruction every two cycles from reset release.
      if (cyc == 20) chk("zero_wait_throughput", 32'(cap_cnt), 32'd10);
      step(cyc);
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: protocol checks and decode-capture scoreboard
  initial begin
    bit          prev_pend;
    logic [31:0] prev_addr;
    int          idle;
    logic [31:0] e;
    prev_pend = 1'b0;
    prev_addr = '0;
    idle      = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("reset_req", 32'(inst_req), 32'd0);
        chk("reset_on", 32'(inst_on), 32'd0);
        chk("reset_instr", instrF, 32'd0);
        prev_pend = 1'b0;
        idle      = 0;
      end else begin
        chk("const_wr", 32'(inst_wr), 32'd0);
        chk("const_size", 32'(inst_size), 32'd2);
        chk("const_wdata", inst_wdata, 32'd0);
        if (inst_req) begin
          chk("req_addr", inst_addr, pcF);
          chk("req_gate", 32'({inst_en, flush}), 32'd2);
          chk("req_single", 32'(out_pend | inst_data_ok), 32'd0);
        end
        if (prev_pend && !flush) begin
          chk("req_hold", 32'(inst_req), 32'd1);
          chk("req_addr_stable", inst_addr, prev_addr);
        end
        if (out_pend && !inst_data_ok) chk("stall_in_flight", 32'(inst_on), 32'd1);
        if (inst_on) chk("stall_cause", 32'(inst_req | out_pend | inst_data_ok), 32'd1);

        if (!inst_on && !longstall && !flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fetch_instr: got %h expected none at %0t", instrF, $time);
          end else begin
            e = exp_q.pop_front();
            chk("fetch_instr", instrF, e);
          end
          cap_flag = 1'b1;
          cap_cnt++;
          idle = 0;
        end else begin
          idle++;
          if (idle > 60) begin
            checks++;
            failures++;
            $display("FAIL fetch_progress: got %0d idle cycles expected at most 60 at %0t", idle, $time);
            idle = 0;
          end
        end

        if (inst_req && inst_addr_ok) begin
          hs_flag = 1'b1;
          hs_addr = inst_addr;
        end
        prev_pend = inst_req && !inst_addr_ok;
        prev_addr = inst_addr;
      end
    end
  end

endmodule
